mon_host_tx: RTL and testbench

MON_HOST_TX -- requirements
Module: mon_host_tx

---
 rtl/mon_pkg.sv | 24 ++
 rtl/mon_pkt_fifo.sv | 62 ++++++
 rtl/mon_host_tx.sv | 162 ++++++++++++++++
 tb/tb_mon_host_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared definitions for the monitor-bus host transmitter: packet layout,
// serializer state encoding and default inter-packet gap.
package mon_pkg;

   localparam int MON_PKT_W   = 40;
   localparam int MON_OP_MSB  = 39;
   localparam int MON_OP_LSB  = 24;
   localparam int MON_GAP_DEF = 2;
   localparam int MON_CNT_W   = 6;

   localparam logic [MON_CNT_W-1:0] MON_DATA_LAST = 6'd39;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_GAP   = 2'd3
   } mon_state_e;

   function automatic logic mon_msb(input logic [MON_PKT_W-1:0] value);
      return value[MON_PKT_W-1];
   endfunction

endpackage

// File: rtl/mon_pkt_fifo.sv
// Packet FIFO feeding the serializer; pointers wrap naturally because DEPTH
// is a power of two, and pushes while full leave the storage untouched.
module mon_pkt_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [3:0]       level,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [3:0]       count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == 4'(DEPTH));
   assign empty     = (count_r == 4'd0);
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign dout      = mem_r[rd_ptr_r];
   assign level     = count_r;

   // Pointer and occupancy tracking; simultaneous push and pop keeps the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= 4'd0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 4'd1;
            2'b01:   count_r <= count_r - 4'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; only accepted pushes write.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

endmodule

// File: rtl/mon_host_tx.sv
// Monitor-bus host transmitter: queues 40-bit packets and serializes each as
// a start bit, 40 data bits MSB first, then GAP idle-high bit times.
module mon_host_tx
   import mon_pkg::*;
#(
   parameter int GAP   = MON_GAP_DEF,
   parameter int DEPTH = 4
) (
   input  logic                 mon_clk,
   input  logic                 reset_n,
   input  logic [MON_PKT_W-1:0] pkt_data,
   input  logic                 pkt_valid,
   output logic                 pkt_ready,
   output logic                 to_mon,
   output logic                 busy,
   output logic [3:0]           level,
   output logic                 tx_done
);

   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

   mon_state_e             state_r;
   mon_state_e             state_nx_s;
   logic [MON_PKT_W-1:0]   shift_r;
   logic [MON_CNT_W-1:0]   bit_cnt_r;
   logic [3:0]             gap_cnt_r;
   logic                   to_mon_r;
   logic                   busy_r;
   logic                   tx_done_r;
   logic                   to_mon_s;
   logic                   busy_s;
   logic                   tx_done_s;
   logic                   pop_s;
   logic                   push_s;
   logic [MON_PKT_W-1:0]   fifo_dout_s;
   logic [3:0]             level_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;

   assign pkt_ready = ~fifo_full_s;
   assign push_s    = pkt_valid & pkt_ready;
   assign level     = level_s;
   assign to_mon    = to_mon_r;
   assign busy      = busy_r;
   assign tx_done   = tx_done_r;

   mon_pkt_fifo #(
      .WIDTH (MON_PKT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (mon_clk),
      .rst_n (reset_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (pkt_data),
      .dout  (fifo_dout_s),
      .level (level_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Serializer state register.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode plus the line value, busy and done for this state.
   always_comb begin
      state_nx_s = state_r;
      pop_s      = 1'b0;
      to_mon_s   = 1'b1;
      busy_s     = (state_r != ST_IDLE);
      tx_done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               state_nx_s = ST_START;
               pop_s      = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            to_mon_s   = 1'b0;
            state_nx_s = ST_DATA;
         end
         ST_DATA: begin
            to_mon_s = mon_msb(shift_r);
            if (bit_cnt_r == 6'd0) begin
               state_nx_s = ST_GAP;
            end else begin
               state_nx_s = ST_DATA;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == 4'd0) begin
               tx_done_s = 1'b1;
               if (!fifo_empty_s) begin
                  state_nx_s = ST_START;
                  pop_s      = 1'b1;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else begin
               state_nx_s = ST_GAP;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Shift register and bit/gap counters; the shifter only loads on a pop.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_r   <= '0;
         bit_cnt_r <= 6'd0;
         gap_cnt_r <= 4'd0;
      end else begin
         if (pop_s) begin
            shift_r <= fifo_dout_s;
         end else if (state_r == ST_DATA) begin
            shift_r <= {shift_r[MON_PKT_W-2:0], 1'b0};
         end else begin
            shift_r <= shift_r;
         end
         if (state_r == ST_START) begin
            bit_cnt_r <= MON_DATA_LAST;
         end else if ((state_r == ST_DATA) && (bit_cnt_r != 6'd0)) begin
            bit_cnt_r <= bit_cnt_r - 6'd1;
         end else begin
            bit_cnt_r <= bit_cnt_r;
         end
         if ((state_r == ST_DATA) && (bit_cnt_r == 6'd0)) begin
            gap_cnt_r <= GAP_LAST;
         end else if ((state_r == ST_GAP) && (gap_cnt_r != 4'd0)) begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
         end else begin
            gap_cnt_r <= gap_cnt_r;
         end
      end
   end

   // Output registers: the line trails the state by one bit time.
   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         to_mon_r  <= 1'b1;
         busy_r    <= 1'b0;
         tx_done_r <= 1'b0;
      end else begin
         to_mon_r  <= to_mon_s;
         busy_r    <= busy_s;
         tx_done_r <= tx_done_s;
      end
   end

endmodule

// File: tb/tb_mon_host_tx.sv
// Randomized bench for mon_host_tx: a frame-schedule model predicts line,
// busy, done, level and ready every cycle; a second GAP=1 instance is also probed.
module tb_mon_host_tx;

   localparam int GAP_M   = 2;
   localparam int DEPTH_M = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [39:0] pkt_data;
   logic        pkt_valid;
   logic        pkt_ready;
   logic        to_mon;
   logic        busy;
   logic [3:0]  level;
   logic        tx_done;

   logic [39:0] d1;
   logic        v1;
   logic        ready1;
   logic        line1;
   logic        busy1;
   logic [3:0]  level1;
   logic        done1;

   mon_host_tx #(.GAP(GAP_M), .DEPTH(DEPTH_M)) dut (
      .mon_clk   (clk),
      .reset_n   (reset_n),
      .pkt_data  (pkt_data),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .to_mon    (to_mon),
      .busy      (busy),
      .level     (level),
      .tx_done   (tx_done)
   );

   mon_host_tx #(.GAP(1), .DEPTH(DEPTH_M)) dut_g1 (
      .mon_clk   (clk),
      .reset_n   (reset_n),
      .pkt_data  (d1),
      .pkt_valid (v1),
      .pkt_ready (ready1),
      .to_mon    (line1),
      .busy      (busy1),
      .level     (level1),
      .tx_done   (done1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: each accepted packet gets a line start edge s; it is popped at s-1.
   int          edge_n = 0;
   int          fs[$];
   logic [39:0] fd[$];
   logic [39:0] tx_q[$];
   int          pop_idx, cur_idx, exp_level, last_s;
   int          peak, done_cnt, cur_k;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_line(input logic [39:0] d, input int k);
      if (k == 0) return 1'b0;
      else if (k >= 1 && k <= 40) return d[40-k];
      else return 1'b1;
   endfunction

   task automatic model_reset();
      fs.delete();
      fd.delete();
      pop_idx   = 0;
      cur_idx   = 0;
      exp_level = 0;
      last_s    = -1000;
   endtask

   task automatic model_edge();
      int s;
      if (pkt_valid && exp_level != DEPTH_M) begin
         s = edge_n + 2;
         if (last_s + 41 + GAP_M > s) s = last_s + 41 + GAP_M;
         fs.push_back(s);
         fd.push_back(pkt_data);
         last_s = s;
         exp_level++;
         if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      while (pop_idx < fs.size() && fs[pop_idx] - 1 <= edge_n) begin
         pop_idx++;
         exp_level--;
      end
   endtask

   task automatic check_outputs();
      logic e_line, e_busy, e_done;
      while (cur_idx < fs.size() && edge_n >= fs[cur_idx] + 41 + GAP_M) cur_idx++;
      e_line = 1'b1; e_busy = 1'b0; e_done = 1'b0; cur_k = -1;
      if (cur_idx < fs.size() && edge_n >= fs[cur_idx]) begin
         cur_k  = edge_n - fs[cur_idx];
         e_line = exp_line(fd[cur_idx], cur_k);
         e_busy = 1'b1;
         e_done = (cur_k == 40 + GAP_M);
      end
      check_val("to_mon", to_mon, e_line);
      check_val("busy", busy, e_busy);
      check_val("tx_done", tx_done, e_done);
      check_val("level", level, exp_level);
      check_val("pkt_ready", pkt_ready, exp_level != DEPTH_M);
      if (int'(level) > peak) peak = int'(level);
      if (tx_done) done_cnt++;
   endtask

   task automatic check_reset_vals();
      check_val("rst_to_mon", to_mon, 1'b1);
      check_val("rst_ready", pkt_ready, 1'b1);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_level", level, 4'd0);
      check_val("rst_done", tx_done, 1'b0);
   endtask

   task automatic drive();
      if (tx_q.size() > 0) begin
         pkt_valid = 1'b1;
         pkt_data  = tx_q[0];
      end else begin
         pkt_valid = 1'b0;
         pkt_data  = {8'($urandom), 32'($urandom)};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      if (reset_n) model_edge();
      @(negedge clk);
      if (reset_n) check_outputs();
      else check_reset_vals();
      drive();
   endtask

   task automatic drain(input int max_cyc);
      int i = 0;
      while (!(tx_q.size() == 0 && exp_level == 0 && edge_n >= last_s + 41 + GAP_M)
             && i < max_cyc) begin
         tick();
         i++;
      end
      check_val("drain_timeout", i >= max_cyc, 1'b0);
      tick();
      tick();
   endtask

   function automatic logic [39:0] rnd_pkt();
      return {8'($urandom), 32'($urandom)};
   endfunction

   initial begin
      int i;
      int done1_cnt;
      logic [39:0] pa, pb;
      logic e1;
      reset_n = 1'b0; pkt_valid = 1'b0; pkt_data = 40'd0;
      v1 = 1'b0; d1 = 40'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals();
      reset_n = 1'b1;

      // Single known packet
      done_cnt = 0;
      tx_q.push_back(40'hC7_0000_0001);
      drive();
      drain(200);
      check_val("single_done_cnt", done_cnt, 1);

      // Three back-to-back packets
      peak = 0; done_cnt = 0;
      for (int k = 0; k < 3; k++) tx_q.push_back(rnd_pkt());
      drive();
      drain(400);
      check_val("b2b_peak", peak, 2);
      check_val("b2b_done_cnt", done_cnt, 3);

      // Six packets: FIFO fills, sixth waits for ready
      peak = 0; done_cnt = 0;
      for (int k = 0; k < 6; k++) tx_q.push_back(rnd_pkt());
      drive();
      drain(700);
      check_val("full_peak", peak, 4);
      check_val("full_done_cnt", done_cnt, 6);

      // Random traffic
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(99) < 3) begin
            tx_q.push_back(rnd_pkt());
            drive();
         end
         tick();
      end
      drain(1000);

      // Reset in the middle of a frame with packets still queued
      for (int k = 0; k < 3; k++) tx_q.push_back(rnd_pkt());
      drive();
      i = 0;
      cur_k = -1;
      while (cur_k != 17 && i < 100) begin
         tick();
         i++;
      end
      check_val("bit17_timeout", i >= 100, 1'b0);
      reset_n = 1'b0;
      #1;
      check_val("midrst_to_mon", to_mon, 1'b1);
      check_val("midrst_level", level, 4'd0);
      check_val("midrst_busy", busy, 1'b0);
      model_reset();
      tx_q.delete();
      pkt_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      done_cnt = 0;
      tx_q.push_back(rnd_pkt());
      drive();
      drain(200);
      check_val("postrst_done_cnt", done_cnt, 1);

      // GAP=1 instance: two queued packets, 42-cycle start-to-start
      pa = rnd_pkt();
      pb = rnd_pkt();
      done1_cnt = 0;
      v1 = 1'b1;
      d1 = pa;
      for (int j = 0; j < 90; j++) begin
         tick();
         if (j < 2) e1 = 1'b1;
         else if (j < 44) e1 = exp_line(pa, j - 2);
         else e1 = exp_line(pb, j - 44);
         check_val("g1_line", line1, e1);
         check_val("g1_busy", busy1, (j >= 2 && j <= 85));
         if (done1) done1_cnt++;
         if (j == 0) begin
            check_val("g1_ready", ready1, 1'b1);
            d1 = pb;
         end
         if (j == 1) begin
            check_val("g1_level", level1, 4'd1);
            v1 = 1'b0;
         end
      end
      check_val("g1_done_cnt", done1_cnt, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
